// File: rtl/dds_cfg_loader.sv
// dds_cfg_loader
//   Writer side of the DDS parameter-load interface. Accepts a valid/ready
//   stream of words ordered per channel as theta, delta, ampl. Each accepted
//   word is written to the DDS address/data port one cycle later. After
//   3*NUM_CH words the loader arms, then holds the DDS start line high.
//
// Ports
//   clk, a_rst_n  clock, asynchronous active-low reset
//   i_load        pulse: clear the DDS and begin a new load
//   i_stop        pulse: stop the DDS and return to idle (wins over i_load)
//   i_s_valid     stream word valid
//   o_s_ready     stream ready (high for the whole LOAD state)
//   i_s_data      stream word, passed to the DDS bit-exact
//   o_dds_rst     one-cycle DDS clear at the start of every load
//   o_dds_start   DDS start, high while running
//   o_dds_addrs   DDS FIFO select; IDLE_ADDR when no write is in flight
//   o_dds_data    DDS FIFO data; zero when no write is in flight
//   o_busy        high while clearing, loading or arming
//   o_done        one-cycle pulse on the first running cycle
module dds_cfg_loader #(
  parameter int                SIG_WIDTH = 16,
  parameter int                NUM_CH    = 8,
  parameter int                ADDR_W    = 9,
  parameter logic [ADDR_W-1:0] THETAS    = ADDR_W'(0),
  parameter logic [ADDR_W-1:0] DELTAS    = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] AMPLS     = ADDR_W'(2),
  parameter logic [ADDR_W-1:0] IDLE_ADDR = {ADDR_W{1'b1}}
) (
  input  logic                        clk,
  input  logic                        a_rst_n,
  input  logic                        i_load,
  input  logic                        i_stop,
  input  logic                        i_s_valid,
  output logic                        o_s_ready,
  input  logic signed [SIG_WIDTH-1:0] i_s_data,
  output logic                        o_dds_rst,
  output logic                        o_dds_start,
  output logic        [ADDR_W-1:0]    o_dds_addrs,
  output logic signed [SIG_WIDTH-1:0] o_dds_data,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_ARM  = 3'd3,
    ST_RUN  = 3'd4
  } state_t;

  state_t                      state_q;
  state_t                      state_nx;
  logic        [1:0]           sel_q;
  logic        [CH_W-1:0]      chan_q;
  logic                        wr_p0;
  logic                        last_word_p0;
  logic        [ADDR_W-1:0]    addr_p1;
  logic signed [SIG_WIDTH-1:0] data_p1;
  logic                        done_p1;

  function automatic logic [ADDR_W-1:0] sel_addr(input logic [1:0] sel);
    case (sel)
      2'd0:    sel_addr = THETAS;
      2'd1:    sel_addr = DELTAS;
      default: sel_addr = AMPLS;
    endcase
  endfunction

  // An accepted word is only forwarded when no load/stop command arrives in
  // the same cycle; an aborted load never writes the word taken on the abort.
  assign wr_p0        = (state_q == ST_LOAD) && i_s_valid && !i_load && !i_stop;
  assign last_word_p0 = (sel_q == 2'd2) && (chan_q == LAST_CH);

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    if (state_q == ST_IDLE) begin
      if (i_load) state_nx = ST_CLR;
    end else if (i_stop) begin
      state_nx = ST_IDLE;
    end else if (i_load) begin
      state_nx = ST_CLR;
    end else begin
      case (state_q)
        ST_CLR:  state_nx = ST_LOAD;
        ST_LOAD: if (wr_p0 && last_word_p0) state_nx = ST_ARM;
        ST_ARM:  state_nx = ST_RUN;
        default: state_nx = state_q;
      endcase
    end
  end

  always_comb begin
    o_s_ready   = (state_q == ST_LOAD);
    o_dds_rst   = (state_q == ST_CLR);
    o_dds_start = (state_q == ST_RUN);
    o_busy      = (state_q == ST_CLR) || (state_q == ST_LOAD) || (state_q == ST_ARM);
  end

  // ---- stage p0 -> p1: word/channel counters and registered write port ----
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      sel_q   <= 2'd0;
      chan_q  <= '0;
      addr_p1 <= IDLE_ADDR;
      data_p1 <= '0;
      done_p1 <= 1'b0;
    end else begin
      if (state_q == ST_CLR) begin
        sel_q  <= 2'd0;
        chan_q <= '0;
      end else if (wr_p0) begin
        if (sel_q == 2'd2) begin
          sel_q  <= 2'd0;
          chan_q <= chan_q + CH_W'(1);
        end else begin
          sel_q <= sel_q + 2'd1;
        end
      end
      addr_p1 <= wr_p0 ? sel_addr(sel_q) : IDLE_ADDR;
      data_p1 <= wr_p0 ? i_s_data : '0;
      done_p1 <= (state_q == ST_ARM) && (state_nx == ST_RUN);
    end
  end

  assign o_dds_addrs = addr_p1;
  assign o_dds_data  = data_p1;
  assign o_done      = done_p1;

endmodule

// File: tb/tb_dds_cfg_loader.sv
module tb_dds_cfg_loader;
  localparam int SW  = 16;
  localparam int NCH = 2;
  localparam int AW  = 9;
  localparam int NW  = 3 * NCH;
  localparam logic [AW-1:0] IDLE_A = 9'h1FF;

  logic                 clk = 1'b0;
  logic                 a_rst_n = 1'b0;
  logic                 i_load = 1'b0;
  logic                 i_stop = 1'b0;
  logic                 i_s_valid = 1'b0;
  logic signed [SW-1:0] i_s_data = '0;
  logic                 o_s_ready;
  logic                 o_dds_rst;
  logic                 o_dds_start;
  logic        [AW-1:0] o_dds_addrs;
  logic signed [SW-1:0] o_dds_data;
  logic                 o_busy;
  logic                 o_done;
  logic        [SW-1:0] dds_data_u;

  int checks = 0;
  int errors = 0;

  assign dds_data_u = o_dds_data;

  always #5 clk = ~clk;

  dds_cfg_loader #(
    .SIG_WIDTH (SW),
    .NUM_CH    (NCH),
    .ADDR_W    (AW)
  ) dut (
    .clk         (clk),
    .a_rst_n     (a_rst_n),
    .i_load      (i_load),
    .i_stop      (i_stop),
    .i_s_valid   (i_s_valid),
    .o_s_ready   (o_s_ready),
    .i_s_data    (i_s_data),
    .o_dds_rst   (o_dds_rst),
    .o_dds_start (o_dds_start),
    .o_dds_addrs (o_dds_addrs),
    .o_dds_data  (o_dds_data),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spec-level address map: word k of a load goes to theta/delta/ampl by k mod 3.
  function automatic logic [AW-1:0] addr_of(input int k);
    case (k % 3)
      0:       addr_of = AW'(0);
      1:       addr_of = AW'(1);
      default: addr_of = AW'(2);
    endcase
  endfunction

  task automatic chk_idle_port(input string tag);
    chk({tag, "_addr"}, o_dds_addrs, IDLE_A);
    chk({tag, "_data"}, dds_data_u, '0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, o_s_ready, 0);
    chk({tag, "_rst"}, o_dds_rst, 0);
    chk({tag, "_start"}, o_dds_start, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk_idle_port(tag);
  endtask

  // Full load from any state. mode 0: valid always high, 1: valid toggles
  // 1/0, 2: valid random. Expected port activity is derived from the word
  // list and the handshake cycles chosen here.
  task automatic do_load(input int mode);
    logic [SW-1:0] words[NW];
    int  k;
    int  cyc;
    bit  hs_prev;
    bit  v;
    for (int i = 0; i < NW; i++) words[i] = SW'($urandom);
    i_load = 1'b1;
    tick();
    i_load = 1'b0;
    chk("clr_rst", o_dds_rst, 1);
    chk("clr_start", o_dds_start, 0);
    chk("clr_busy", o_busy, 1);
    chk("clr_ready", o_s_ready, 0);
    chk("clr_done", o_done, 0);
    chk_idle_port("clr");
    tick();
    k = 0;
    cyc = 0;
    hs_prev = 1'b0;
    while (k < NW && cyc < 200) begin
      chk("load_ready", o_s_ready, 1);
      chk("load_rst", o_dds_rst, 0);
      chk("load_start", o_dds_start, 0);
      chk("load_busy", o_busy, 1);
      if (hs_prev) begin
        chk("load_addr", o_dds_addrs, addr_of(k - 1));
        chk("load_data", dds_data_u, words[k - 1]);
      end else begin
        chk_idle_port("load_gap");
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = ($urandom_range(99) < 60);
      endcase
      if (v) begin
        i_s_valid = 1'b1;
        i_s_data  = words[k];
        k++;
      end else begin
        i_s_valid = 1'b0;
        i_s_data  = SW'($urandom);
      end
      hs_prev = v;
      cyc++;
      tick();
    end
    i_s_valid = 1'b0;
    i_s_data  = '0;
    chk("load_all_words", k, NW);
    // arm: final write on the port, start still low
    chk("arm_ready", o_s_ready, 0);
    chk("arm_addr", o_dds_addrs, addr_of(NW - 1));
    chk("arm_data", dds_data_u, words[NW - 1]);
    chk("arm_start", o_dds_start, 0);
    chk("arm_busy", o_busy, 1);
    chk("arm_done", o_done, 0);
    tick();
    chk("run_start", o_dds_start, 1);
    chk("run_done", o_done, 1);
    chk("run_busy", o_busy, 0);
    chk("run_ready", o_s_ready, 0);
    chk_idle_port("run");
    tick();
    chk("run2_start", o_dds_start, 1);
    chk("run2_done", o_done, 0);
    chk_idle_port("run2");
  endtask

  // Starts a load and pushes n words with valid held high.
  task automatic partial_load(input int n);
    i_load = 1'b1;
    tick();
    i_load = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      i_s_valid = 1'b1;
      i_s_data  = SW'($urandom);
      tick();
      chk("part_addr", o_dds_addrs, addr_of(i));
    end
    i_s_valid = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk_reset("rst");
    a_rst_n = 1'b1;
    tick();
    chk_reset("idle");

    // stop ignored in idle
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    chk_reset("idle_stop");

    // continuous, toggled and random valid; each reload starts from RUN
    do_load(0);
    do_load(1);
    do_load(2);

    // stop while running
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    chk_reset("run_stop");
    tick();
    chk_reset("run_stop2");

    // load and stop together mid-load: stop wins, no start
    partial_load(2);
    i_load = 1'b1;
    i_stop = 1'b1;
    tick();
    i_load = 1'b0;
    i_stop = 1'b0;
    chk_reset("ldstop");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ldstop_start", o_dds_start, 0);
      chk("ldstop_ready", o_s_ready, 0);
    end

    // reload after three words: counting restarts at theta
    partial_load(3);
    do_load(2);

    // asynchronous reset mid-load at word 5
    partial_load(5);
    #3;
    a_rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    tick();
    chk_reset("async_rst_hold");
    a_rst_n = 1'b1;
    tick();
    chk_reset("async_rst_idle");
    do_load(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
